// File: rtl/id_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe
// Description : ID/EX pipeline register for a 5-stage MIPS-style core, with
//               load-use hazard detection and a saturating stall counter.
//               Per-edge priority: rst > flush > hold > load_use > capture.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               flush, hold         - redirect bubble / external freeze
//               id_*                - decoded instruction fields from ID
//               ex_*                - registered EX-stage copies
//               stall               - freeze PC and IF/ID this cycle
//               stall_cnt           - count of load-use bubbles (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipe #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_busA,
  input  logic [DATA_W-1:0] id_busB,
  input  logic [DATA_W-1:0] id_imm32,
  input  logic [DATA_W-1:0] id_pc,
  input  logic              id_ALUsrc,
  input  logic              id_RegWr,
  input  logic              id_RegDst,
  input  logic              id_MemRead,
  input  logic              id_MemWr,
  input  logic              id_MemtoReg,
  input  logic [3:0]        id_ALUop,
  output logic              ex_valid,
  output logic [4:0]        ex_Rs,
  output logic [4:0]        ex_Rt,
  output logic [4:0]        ex_Rd,
  output logic [DATA_W-1:0] ex_busA,
  output logic [DATA_W-1:0] ex_busB,
  output logic [DATA_W-1:0] ex_imm32,
  output logic [DATA_W-1:0] ex_pc,
  output logic              ex_ALUsrc,
  output logic              ex_RegWr,
  output logic              ex_RegDst,
  output logic              ex_MemRead,
  output logic              ex_MemWr,
  output logic              ex_MemtoReg,
  output logic [3:0]        ex_ALUop,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] busA;
    logic [DATA_W-1:0] busB;
    logic [DATA_W-1:0] imm32;
    logic [DATA_W-1:0] pc;
    logic              alusrc;
    logic              regwr;
    logic              regdst;
    logic              memread;
    logic              memwr;
    logic              memtoreg;
    logic [3:0]        aluop;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;

  // A load in EX whose destination is read by the instruction in ID. Register
  // $0 is hard-wired to zero, so a "load" into it never creates a dependency.
  assign load_use = ex_q.valid & ex_q.memread & (ex_q.rt != 5'd0) & id_valid &
                    ((ex_q.rt == id_rs) | (id_uses_rt & (ex_q.rt == id_rt)));

  // A flush already kills the ID instruction and a hold freezes everything,
  // so in either case the front end must not be told to stall.
  assign stall = load_use & ~flush & ~hold;

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush) begin
      ex_d = '0;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (load_use) begin
      // The bubble clears ex_MemRead, so the same ID instruction cannot
      // trigger a second bubble on the next edge.
      ex_d = '0;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      ex_d.valid    = id_valid;
      ex_d.rs       = id_rs;
      ex_d.rt       = id_rt;
      ex_d.rd       = id_rd;
      ex_d.busA     = id_busA;
      ex_d.busB     = id_busB;
      ex_d.imm32    = id_imm32;
      ex_d.pc       = id_pc;
      ex_d.alusrc   = id_ALUsrc   & id_valid;
      ex_d.regwr    = id_RegWr    & id_valid;
      ex_d.regdst   = id_RegDst   & id_valid;
      ex_d.memread  = id_MemRead  & id_valid;
      ex_d.memwr    = id_MemWr    & id_valid;
      ex_d.memtoreg = id_MemtoReg & id_valid;
      ex_d.aluop    = id_ALUop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_Rs       = ex_q.rs;
  assign ex_Rt       = ex_q.rt;
  assign ex_Rd       = ex_q.rd;
  assign ex_busA     = ex_q.busA;
  assign ex_busB     = ex_q.busB;
  assign ex_imm32    = ex_q.imm32;
  assign ex_pc       = ex_q.pc;
  assign ex_ALUsrc   = ex_q.alusrc;
  assign ex_RegWr    = ex_q.regwr;
  assign ex_RegDst   = ex_q.regdst;
  assign ex_MemRead  = ex_q.memread;
  assign ex_MemWr    = ex_q.memwr;
  assign ex_MemtoReg = ex_q.memtoreg;
  assign ex_ALUop    = ex_q.aluop;
  assign stall_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_pipe
// Description : Self-checking bench for id_ex_pipe. Table of directed vectors
//               followed by hand-written hold, saturation and reset sequences.
//               The counter is built 8 bits wide so saturation is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, flush, hold, id_valid, id_uses_rt;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic [DW-1:0] id_busA, id_busB, id_imm32, id_pc;
  logic          id_ALUsrc, id_RegWr, id_RegDst, id_MemRead, id_MemWr, id_MemtoReg;
  logic [3:0]    id_ALUop;
  logic          ex_valid, ex_ALUsrc, ex_RegWr, ex_RegDst, ex_MemRead, ex_MemWr, ex_MemtoReg;
  logic [4:0]    ex_Rs, ex_Rt, ex_Rd;
  logic [DW-1:0] ex_busA, ex_busB, ex_imm32, ex_pc;
  logic [3:0]    ex_ALUop;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_busA(id_busA), .id_busB(id_busB), .id_imm32(id_imm32), .id_pc(id_pc),
    .id_ALUsrc(id_ALUsrc), .id_RegWr(id_RegWr), .id_RegDst(id_RegDst),
    .id_MemRead(id_MemRead), .id_MemWr(id_MemWr), .id_MemtoReg(id_MemtoReg),
    .id_ALUop(id_ALUop),
    .ex_valid(ex_valid), .ex_Rs(ex_Rs), .ex_Rt(ex_Rt), .ex_Rd(ex_Rd),
    .ex_busA(ex_busA), .ex_busB(ex_busB), .ex_imm32(ex_imm32), .ex_pc(ex_pc),
    .ex_ALUsrc(ex_ALUsrc), .ex_RegWr(ex_RegWr), .ex_RegDst(ex_RegDst),
    .ex_MemRead(ex_MemRead), .ex_MemWr(ex_MemWr), .ex_MemtoReg(ex_MemtoReg),
    .ex_ALUop(ex_ALUop), .stall(stall), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic          flush, hold, vld;
    logic [4:0]    rs, rt;
    logic          ut, mr;
    logic [31:0]   busA;
    logic          e_stall, e_valid, e_mr;
    logic [4:0]    e_rs, e_rt;
    logic [31:0]   e_busA;
    logic [7:0]    e_cnt;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(
    input logic f, input logic h, input logic v, input logic [4:0] rs,
    input logic [4:0] rt, input logic ut, input logic mr, input logic [31:0] a,
    input logic es, input logic ev, input logic emr, input logic [4:0] ers,
    input logic [4:0] ert, input logic [31:0] ea, input logic [7:0] ec);
    vec_t r;
    r.flush = f;  r.hold = h; r.vld = v; r.rs = rs; r.rt = rt; r.ut = ut;
    r.mr = mr;    r.busA = a; r.e_stall = es; r.e_valid = ev; r.e_mr = emr;
    r.e_rs = ers; r.e_rt = ert; r.e_busA = ea; r.e_cnt = ec;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Secondary fields are derived from busA/rt so a row only lists the key ones.
  task automatic drv(input logic f, input logic h, input logic v, input logic [4:0] rs,
                     input logic [4:0] rt, input logic ut, input logic mr,
                     input logic [31:0] a);
    flush = f; hold = h; id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ut;
    id_rd = rt ^ 5'h1F; id_busA = a; id_busB = a ^ 32'hA5A5_0000;
    id_imm32 = a + 32'd1; id_pc = a << 2; id_ALUop = a[3:0];
    id_MemRead = mr; id_ALUsrc = mr; id_MemtoReg = mr; id_RegDst = ~mr;
    id_RegWr = 1'b1; id_MemWr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {63'd0, |{ex_valid, ex_Rs, ex_Rt, ex_Rd, ex_busA, ex_busB, ex_imm32,
                      ex_pc, ex_ALUsrc, ex_RegWr, ex_RegDst, ex_MemRead, ex_MemWr,
                      ex_MemtoReg, ex_ALUop, stall_cnt}}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic bub;
    // flush hold vld rs rt ut mr busA | stall valid mr rs rt busA cnt
    tbl[0]  = mk(0,0,1, 1, 5,0,1,32'h100, 0,1,1, 1, 5,32'h100,0); // lw $5
    tbl[1]  = mk(0,0,1, 5, 7,1,0,32'h011, 1,0,0, 0, 0,32'h000,1); // add uses $5
    tbl[2]  = mk(0,0,1, 5, 7,1,0,32'h011, 0,1,0, 5, 7,32'h011,1); // add advances
    tbl[3]  = mk(0,0,1, 2, 5,0,1,32'h200, 0,1,1, 2, 5,32'h200,1); // lw $5
    tbl[4]  = mk(0,0,1, 8, 5,0,0,32'h088, 0,1,0, 8, 5,32'h088,1); // addi rt=5 not read
    tbl[5]  = mk(0,0,1, 3, 0,0,1,32'h300, 0,1,1, 3, 0,32'h300,1); // lw $0
    tbl[6]  = mk(0,0,1, 0, 0,1,0,32'h033, 0,1,0, 0, 0,32'h033,1); // add uses $0
    tbl[7]  = mk(0,0,1, 4, 9,0,1,32'h400, 0,1,1, 4, 9,32'h400,1); // lw $9
    tbl[8]  = mk(1,0,1, 9, 9,1,0,32'h044, 0,0,0, 0, 0,32'h000,1); // hazard + flush
    tbl[9]  = mk(0,0,0, 6,10,0,1,32'h050, 0,0,0, 6,10,32'h050,1); // invalid lw
    tbl[10] = mk(0,0,1,10,11,1,0,32'h066, 0,1,0,10,11,32'h066,1); // no hazard: ex invalid
    tbl[11] = mk(0,0,1, 1,12,0,1,32'h070, 0,1,1, 1,12,32'h070,1); // lw $12
    tbl[12] = mk(0,0,1,12,13,0,1,32'h071, 1,0,0, 0, 0,32'h000,2); // lw $13 uses $12
    tbl[13] = mk(0,0,1,12,13,0,1,32'h071, 0,1,1,12,13,32'h071,2); // lw $13 advances
    tbl[14] = mk(0,0,1,13, 1,1,0,32'h072, 1,0,0, 0, 0,32'h000,3); // add uses $13
    tbl[15] = mk(0,0,1,13, 1,1,0,32'h072, 0,1,0,13, 1,32'h072,3); // add advances
    tbl[16] = mk(0,0,1, 2,14,0,1,32'h080, 0,1,1, 2,14,32'h080,3); // lw $14
    tbl[17] = mk(0,0,1, 3,14,1,0,32'h081, 1,0,0, 0, 0,32'h000,4); // reads $14 via rt
    tbl[18] = mk(0,0,1, 3,14,1,0,32'h081, 0,1,0, 3,14,32'h081,4);

    // Reset with a hazard-looking ID instruction present.
    rst = 1'b1;
    drv(0,0,1,5,5,1,1,32'hDEAD);
    step(); step();
    chk_zero("reset_outputs");
    chk("reset_stall", {63'd0, stall}, 64'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drv(tbl[i].flush, tbl[i].hold, tbl[i].vld, tbl[i].rs, tbl[i].rt,
          tbl[i].ut, tbl[i].mr, tbl[i].busA);
      #4;
      chk($sformatf("row%0d_stall", i), {63'd0, stall}, {63'd0, tbl[i].e_stall});
      step();
      bub = (tbl[i].e_busA == 32'd0);
      chk($sformatf("row%0d_valid", i), {63'd0, ex_valid}, {63'd0, tbl[i].e_valid});
      chk($sformatf("row%0d_memread", i), {63'd0, ex_MemRead}, {63'd0, tbl[i].e_mr});
      chk($sformatf("row%0d_rs_rt", i), {54'd0, ex_Rs, ex_Rt}, {54'd0, tbl[i].e_rs, tbl[i].e_rt});
      chk($sformatf("row%0d_rd", i), {59'd0, ex_Rd}, {59'd0, bub ? 5'd0 : tbl[i].e_rt ^ 5'h1F});
      chk($sformatf("row%0d_busA_B", i), {ex_busA, ex_busB},
          bub ? 64'd0 : {tbl[i].e_busA, tbl[i].e_busA ^ 32'hA5A5_0000});
      chk($sformatf("row%0d_imm_pc", i), {ex_imm32, ex_pc},
          bub ? 64'd0 : {tbl[i].e_busA + 32'd1, tbl[i].e_busA << 2});
      chk($sformatf("row%0d_ctrl", i),
          {57'd0, ex_RegWr, ex_MemWr, ex_ALUsrc, ex_MemtoReg, ex_RegDst, ex_ALUop[1:0]},
          {57'd0, tbl[i].e_valid, 1'b0, tbl[i].e_mr, tbl[i].e_mr,
           tbl[i].e_valid & ~tbl[i].e_mr, bub ? 2'd0 : tbl[i].e_busA[1:0]});
      chk($sformatf("row%0d_cnt", i), {56'd0, stall_cnt}, {56'd0, tbl[i].e_cnt});
    end

    // Hold for three cycles while a load-use hazard is pending.
    drv(0,0,1,1,5,0,1,32'hA0);
    step();
    for (int k = 0; k < 3; k++) begin
      drv(0,1,1,5,7,1,0,32'hB0);
      #4;
      chk($sformatf("hold%0d_stall", k), {63'd0, stall}, 64'd0);
      step();
      chk($sformatf("hold%0d_frozen", k), {ex_busA, 22'd0, ex_Rt, ex_MemRead, ex_valid, stall_cnt},
          {32'hA0, 22'd0, 5'd5, 1'b1, 1'b1, 8'd4});
    end
    drv(0,0,1,5,7,1,0,32'hB0);
    #4;
    chk("hold_release_stall", {63'd0, stall}, 64'd1);
    step();
    chk("hold_release_bubble", {55'd0, ex_valid, stall_cnt}, {55'd0, 1'b0, 8'd5});
    #4;
    chk("hold_after_bubble_stall", {63'd0, stall}, 64'd0);
    step();
    chk("hold_add_captured", {31'd0, ex_valid, ex_busA}, {31'd0, 1'b1, 32'hB0});

    // Drive the counter to saturation: 250 more hazards from 5 reaches 255.
    for (int k = 0; k < 250; k++) begin
      drv(0,0,1,1,5,0,1,32'h10);
      step();
      drv(0,0,1,5,6,1,0,32'h20);
      step();
    end
    chk("sat_reached", {56'd0, stall_cnt}, 64'hFF);
    drv(0,0,1,1,5,0,1,32'h10);
    step();
    drv(0,0,1,5,6,1,0,32'h20);
    #4;
    chk("sat_hazard_stall", {63'd0, stall}, 64'd1);
    step();
    chk("sat_no_wrap", {55'd0, ex_valid, stall_cnt}, {55'd0, 1'b0, 8'hFF});

    // Reset in the middle of a stall.
    drv(0,0,1,1,5,0,1,32'h10);
    step();
    drv(0,0,1,5,6,1,0,32'h20);
    #4;
    chk("pre_reset_stall", {63'd0, stall}, 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero("midstall_reset_outputs");
    #4;
    chk("post_reset_stall", {63'd0, stall}, 64'd0);

    // Reset during hold.
    drv(0,0,1,1,5,0,1,32'h10);
    step();
    drv(0,1,1,5,6,1,0,32'h20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero("hold_reset_outputs");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
